// File: rtl/shift_chain_ctrl.sv
// Sequencer for an N-cell muxed-DFF shift chain: one load cycle, then a
// clamped number of shift cycles (pausable by stall), then a done pulse.
module shift_chain_ctrl #(
  parameter int N  = 4,
  parameter int CW = $clog2(N+1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic [CW-1:0] in_shift,
  input  logic          ser_in,
  input  logic          stall,
  output logic [N-1:0]  R,
  output logic          L,
  output logic          E,
  output logic          w,
  output logic          done
);

  // state | meaning
  // IDLE  | waiting for a request, in_ready high
  // LOAD  | L high for one cycle, chain takes R
  // SHIFT | E high per non-stalled cycle, cnt counts down
  // DONE  | one-cycle done pulse
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  localparam logic [CW-1:0] N_CW   = CW'(N);
  localparam logic [CW-1:0] ONE_CW = CW'(1);

  state_t        state_q, state_d;
  logic [N-1:0]  r_q, r_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept;

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          r_d     = in_data;
          cnt_d   = (in_shift > N_CW) ? N_CW : in_shift;
          state_d = S_LOAD;
        end
      end
      S_LOAD: state_d = (cnt_q == '0) ? S_DONE : S_SHIFT;
      S_SHIFT: begin
        // a stalled cycle neither shifts nor counts
        if (!stall) begin
          cnt_d = cnt_q - ONE_CW;
          if (cnt_q == ONE_CW) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == S_IDLE) && !reset;
    L        = (state_q == S_LOAD);
    E        = (state_q == S_SHIFT) && !stall;
    done     = (state_q == S_DONE);
  end

  assign w = E & ser_in;
  assign R = r_q;

endmodule

// File: tb/tb_shift_chain_ctrl.sv
// Directed bench for shift_chain_ctrl driving four reference chain cells.
module tb_shift_chain_ctrl;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic [2:0] in_shift;
  logic       ser_in;
  logic       stall;
  logic [3:0] R;
  logic       L;
  logic       E;
  logic       w;
  logic       done;

  logic [3:0] chain;

  int n_checks = 0;
  int n_fail   = 0;

  int l_cnt, e_cnt, w_cnt, w_bad, overlap, first_l, first_e, last_e;
  int done_rel, ready_hi, ready_after;
  logic [3:0] chain_at_done;

  shift_chain_ctrl #(.N(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_shift(in_shift), .ser_in(ser_in), .stall(stall),
    .R(R), .L(L), .E(E), .w(w), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference cells: Q <= L ? R : (E ? w_in : Q), shifting toward bit 0
  always @(posedge clk) begin
    if (L) chain <= R;
    else if (E) chain <= {w, chain[3:1]};
  end

  // Observes a sequence whose accept edge has just passed (now = edge + 1).
  task automatic observe(input logic ser, input int s0, input int slen, input int budget);
    int rel;
    l_cnt = 0; e_cnt = 0; w_cnt = 0; w_bad = 0; overlap = 0;
    first_l = 0; first_e = 0; last_e = 0; done_rel = 0; ready_hi = 0;
    chain_at_done = 4'bxxxx;
    rel = 1;
    while (rel <= budget && done_rel == 0) begin
      stall  = (rel >= s0) && (rel < s0 + slen);
      ser_in = ser;
      #1;
      if (L) begin l_cnt++; if (first_l == 0) first_l = rel; end
      if (E) begin e_cnt++; if (first_e == 0) first_e = rel; last_e = rel; end
      if (w) w_cnt++;
      if (w !== (E & ser_in)) w_bad++;
      if (L && E) overlap++;
      if (in_ready) ready_hi++;
      if (done) begin
        done_rel = rel;
        chain_at_done = chain;
      end else begin
        @(posedge clk); #1;
        rel++;
      end
    end
    @(posedge clk); #1;
    stall = 1'b0;
    #1;
    ready_after = int'(in_ready);
  endtask

  task automatic run_seq(input logic [3:0] data, input logic [2:0] shift, input logic ser,
                         input int s0, input int slen, input logic hold,
                         input logic [3:0] nxt_data, input logic [2:0] nxt_shift);
    in_valid = 1'b1;
    in_data  = data;
    in_shift = shift;
    ser_in   = ser;
    @(posedge clk); #1;
    in_valid = hold;
    in_data  = hold ? nxt_data : ~data;
    in_shift = nxt_shift;
    observe(ser, s0, slen, 20);
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = 4'h0; in_shift = 3'd0;
    ser_in = 1'b0; stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_low: got %b want 0", in_ready); end
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready: got %b want 1", in_ready); end
    n_checks++; if ({L, E, w, done} !== 4'b0000) begin n_fail++; $display("FAIL idle_ctrl LEwd: got %b want 0000", {L, E, w, done}); end
    n_checks++; if (R !== 4'b0000) begin n_fail++; $display("FAIL idle_R: got %b want 0000", R); end
  endtask

  task automatic test_zero_shift();
    run_seq(4'b1011, 3'd0, 1'b1, 0, 0, 1'b0, 4'h0, 3'd0);
    n_checks++; if (l_cnt !== 1 || first_l !== 1) begin n_fail++; $display("FAIL k0_load: got cnt %0d at %0d want 1 at 1", l_cnt, first_l); end
    n_checks++; if (e_cnt !== 0) begin n_fail++; $display("FAIL k0_no_E: got %0d want 0", e_cnt); end
    n_checks++; if (done_rel !== 2) begin n_fail++; $display("FAIL k0_done_time: got t+%0d want t+2", done_rel); end
    n_checks++; if (chain_at_done !== 4'b1011) begin n_fail++; $display("FAIL k0_chain: got %b want 1011", chain_at_done); end
    n_checks++; if (ready_after !== 1) begin n_fail++; $display("FAIL k0_ready_after: got %0d want 1", ready_after); end
  endtask

  task automatic test_shift3();
    // stall during LOAD must be ignored
    run_seq(4'b1011, 3'd3, 1'b1, 1, 1, 1'b0, 4'h0, 3'd0);
    n_checks++; if (e_cnt !== 3 || first_e !== 2 || last_e !== 4) begin n_fail++; $display("FAIL k3_E: got %0d cycles %0d..%0d want 3 cycles 2..4", e_cnt, first_e, last_e); end
    n_checks++; if (w_cnt !== 3 || w_bad !== 0) begin n_fail++; $display("FAIL k3_w: got %0d high %0d bad want 3 high 0 bad", w_cnt, w_bad); end
    n_checks++; if (done_rel !== 5) begin n_fail++; $display("FAIL k3_done_time: got t+%0d want t+5", done_rel); end
    n_checks++; if (chain_at_done !== 4'b1111) begin n_fail++; $display("FAIL k3_chain: got %b want 1111", chain_at_done); end
    n_checks++; if (overlap !== 0) begin n_fail++; $display("FAIL k3_L_E_overlap: got %0d want 0", overlap); end
    n_checks++; if (ready_after !== 1) begin n_fail++; $display("FAIL k3_ready_after: got %0d want 1", ready_after); end
  endtask

  task automatic test_stall();
    run_seq(4'b1011, 3'd2, 1'b0, 3, 2, 1'b0, 4'h0, 3'd0);
    n_checks++; if (e_cnt !== 2 || first_e !== 2 || last_e !== 5) begin n_fail++; $display("FAIL stall_E: got %0d cycles %0d..%0d want 2 cycles 2..5", e_cnt, first_e, last_e); end
    n_checks++; if (w_cnt !== 0 || w_bad !== 0) begin n_fail++; $display("FAIL stall_w: got %0d high %0d bad want 0 0", w_cnt, w_bad); end
    n_checks++; if (done_rel !== 6) begin n_fail++; $display("FAIL stall_done_time: got t+%0d want t+6", done_rel); end
    n_checks++; if (chain_at_done !== 4'b0010) begin n_fail++; $display("FAIL stall_chain: got %b want 0010", chain_at_done); end
  endtask

  task automatic test_clamp_back_to_back();
    // in_shift changed to 1 after the accept must not shorten the first run
    run_seq(4'b1111, 3'd7, 1'b0, 0, 0, 1'b1, 4'b0110, 3'd1);
    n_checks++; if (e_cnt !== 4) begin n_fail++; $display("FAIL clamp_E: got %0d want 4", e_cnt); end
    n_checks++; if (done_rel !== 6) begin n_fail++; $display("FAIL clamp_done_time: got t+%0d want t+6", done_rel); end
    n_checks++; if (chain_at_done !== 4'b0000) begin n_fail++; $display("FAIL clamp_chain: got %b want 0000", chain_at_done); end
    n_checks++; if (ready_hi !== 0) begin n_fail++; $display("FAIL b2b_ready_busy: got %0d high cycles want 0", ready_hi); end
    n_checks++; if (ready_after !== 1) begin n_fail++; $display("FAIL b2b_ready_idle: got %0d want 1", ready_after); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    observe(1'b0, 0, 0, 20);
    n_checks++; if (l_cnt !== 1 || first_l !== 1) begin n_fail++; $display("FAIL b2b_second_load: got cnt %0d at %0d want 1 at 1", l_cnt, first_l); end
    n_checks++; if (e_cnt !== 1 || done_rel !== 3) begin n_fail++; $display("FAIL b2b_second_seq: got E %0d done t+%0d want 1 t+3", e_cnt, done_rel); end
    n_checks++; if (chain_at_done !== 4'b0011) begin n_fail++; $display("FAIL b2b_second_chain: got %b want 0011", chain_at_done); end
  endtask

  task automatic test_reset_abort();
    int extra_done, extra_e;
    in_valid = 1'b1; in_data = 4'b1010; in_shift = 3'd4; ser_in = 1'b1; stall = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    n_checks++; if (E !== 1'b1) begin n_fail++; $display("FAIL abort_in_shift: got E %b want 1", E); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL abort_ready_in_reset: got %b want 0", in_ready); end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    n_checks++; if ({in_ready, L, E, done} !== 4'b1000) begin n_fail++; $display("FAIL abort_idle rLEd: got %b want 1000", {in_ready, L, E, done}); end
    n_checks++; if (R !== 4'b0000) begin n_fail++; $display("FAIL abort_R: got %b want 0000", R); end
    extra_done = 0; extra_e = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #2;
      if (done) extra_done++;
      if (E) extra_e++;
    end
    n_checks++; if (extra_done !== 0 || extra_e !== 0) begin n_fail++; $display("FAIL abort_no_done: got done %0d E %0d want 0 0", extra_done, extra_e); end
    run_seq(4'b0101, 3'd1, 1'b1, 0, 0, 1'b0, 4'h0, 3'd0);
    n_checks++; if (done_rel !== 3 || e_cnt !== 1) begin n_fail++; $display("FAIL post_abort_seq: got done t+%0d E %0d want t+3 1", done_rel, e_cnt); end
    n_checks++; if (chain_at_done !== 4'b1010) begin n_fail++; $display("FAIL post_abort_chain: got %b want 1010", chain_at_done); end
    n_checks++; if (R !== 4'b0101) begin n_fail++; $display("FAIL post_abort_R: got %b want 0101", R); end
  endtask

  initial begin
    test_reset();
    test_zero_shift();
    test_shift3();
    test_stall();
    test_clamp_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
